// File: rtl/d_flipflop_cell.sv
// Single edge-triggered register with load enable and asynchronous reset.
// Instantiated twice by d_flipflop to build the two flop-style outputs.
`timescale 1ns/1ps
module d_flipflop_cell #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/d_flipflop.sv
// D storage reference cell: two independent edge-triggered flops plus a
// clock-high transparent latch, each with true and complementary outputs.
`timescale 1ns/1ps
module d_flipflop #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_nbl,
  output logic [WIDTH-1:0] qb_nbl,
  output logic [WIDTH-1:0] q_bl,
  output logic [WIDTH-1:0] qb_bl,
  output logic [WIDTH-1:0] q_l,
  output logic [WIDTH-1:0] qb_l
);

  logic [WIDTH-1:0] lat_q;

  d_flipflop_cell #(
    .WIDTH  (WIDTH),
    .RST_VAL(RST_VAL)
  ) u_cell_nbl (
    .clk(clk),
    .rst(rst),
    .en (en),
    .d  (d),
    .q  (q_nbl)
  );

  d_flipflop_cell #(
    .WIDTH  (WIDTH),
    .RST_VAL(RST_VAL)
  ) u_cell_bl (
    .clk(clk),
    .rst(rst),
    .en (en),
    .d  (d),
    .q  (q_bl)
  );

  // Intentional latch: transparent while clk and en are both high.
  always_latch begin
    if (rst) begin
      lat_q <= RST_VAL;
    end else if (clk && en) begin
      lat_q <= d;
    end
  end

  assign q_l    = lat_q;
  assign qb_nbl = ~q_nbl;
  assign qb_bl  = ~q_bl;
  assign qb_l   = ~lat_q;

endmodule

// File: tb/tb_d_flipflop.sv
// Scoreboard bench for d_flipflop: the stimulus thread queues expected
// outputs with their sample times, the checker thread pops and compares them.
`timescale 1ns/1ps
module tb_d_flipflop;

  localparam int           W  = 4;
  localparam logic [W-1:0] RV = 4'h6;
  localparam logic [W-1:0] DA = 4'h9;
  localparam logic [W-1:0] DB = 4'h3;
  localparam logic [W-1:0] DZ = 4'h0;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] d;
  logic [W-1:0] q_nbl, qb_nbl, q_bl, qb_bl, q_l, qb_l;

  realtime      timeQ[$];
  string        tagQ[$];
  logic [W-1:0] flopQ[$];
  logic [W-1:0] latchQ[$];

  int vectors     = 0;
  int miscompares = 0;
  bit done        = 1'b0;

  d_flipflop #(
    .WIDTH  (W),
    .RST_VAL(RV)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .d     (d),
    .q_nbl (q_nbl),
    .qb_nbl(qb_nbl),
    .q_bl  (q_bl),
    .qb_bl (qb_bl),
    .q_l   (q_l),
    .qb_l  (qb_l)
  );

  // Rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic waitUntil(input realtime t);
    if (t > $realtime) #(t - $realtime);
  endtask

  task automatic applyStimulus(input realtime t, input logic r, input logic e, input logic [W-1:0] dv);
    waitUntil(t);
    rst = r;
    en  = e;
    d   = dv;
  endtask

  task automatic expectAt(input realtime t, input string tag, input logic [W-1:0] f, input logic [W-1:0] l);
    timeQ.push_back(t);
    tagQ.push_back(tag);
    flopQ.push_back(f);
    latchQ.push_back(l);
  endtask

  // Stimulus drives avoid clock edges; expectations are queued as each drive is made.
  initial begin
    rst = 1'b1; en = 1'b0; d = DZ;
    expectAt(2,  "rst_pre_edge", RV, RV);
    expectAt(7,  "rst_edge5",    RV, RV);
    applyStimulus(11, 1'b1, 1'b1, DA);
    expectAt(17, "rst_dominates", RV, RV);
    applyStimulus(21, 1'b0, 1'b1, DZ);
    expectAt(23, "release_no_edge", RV, RV);
    expectAt(27, "load0", DZ, DZ);
    applyStimulus(31, 1'b0, 1'b1, DA);
    expectAt(33, "latch_closed_low", DZ, DZ);
    expectAt(37, "loadA", DA, DA);
    applyStimulus(41, 1'b0, 1'b0, DZ);
    expectAt(47, "hold_edge45", DA, DA);
    applyStimulus(51, 1'b0, 1'b0, DB);
    expectAt(57, "hold_edge55", DA, DA);
    applyStimulus(61, 1'b0, 1'b1, DB);
    expectAt(65.5, "transp_B", DB, DB);
    applyStimulus(66, 1'b0, 1'b1, DA);
    expectAt(66.5, "transp_A", DB, DA);
    applyStimulus(67, 1'b0, 1'b1, DB);
    expectAt(67.5, "transp_B2", DB, DB);
    applyStimulus(68, 1'b0, 1'b1, DZ);
    expectAt(68.5, "transp_0", DB, DZ);
    applyStimulus(72, 1'b0, 1'b1, DA);
    expectAt(73,   "low_phase_hold", DB, DZ);
    expectAt(75.5, "edge75", DA, DA);
    applyStimulus(76, 1'b0, 1'b0, DA);
    applyStimulus(77, 1'b0, 1'b0, DB);
    expectAt(78, "en_fall_hold", DA, DA);
    applyStimulus(81, 1'b0, 1'b1, DB);
    expectAt(87, "pre_reset", DB, DB);
    applyStimulus(88, 1'b1, 1'b1, DB);
    expectAt(88.5, "async_rst", RV, RV);
    applyStimulus(91, 1'b0, 1'b1, DA);
    expectAt(93, "rst_released_low", RV, RV);
    expectAt(97, "restore", DA, DA);
    waitUntil(99);
    done = 1'b1;
  end

  // Pops each expectation, waits for its sample time and compares all six outputs.
  initial begin
    realtime      t;
    string        tag;
    logic [W-1:0] ef, el;
    while (!done || timeQ.size() > 0) begin
      wait (timeQ.size() > 0 || done);
      if (timeQ.size() == 0) continue;
      t   = timeQ.pop_front();
      tag = tagQ.pop_front();
      ef  = flopQ.pop_front();
      el  = latchQ.pop_front();
      waitUntil(t);
      checkOutput({tag, ".q_nbl"},  q_nbl,  ef);
      checkOutput({tag, ".q_bl"},   q_bl,   ef);
      checkOutput({tag, ".q_l"},    q_l,    el);
      checkOutput({tag, ".qb_nbl"}, qb_nbl, ~ef);
      checkOutput({tag, ".qb_bl"},  qb_bl,  ~ef);
      checkOutput({tag, ".qb_l"},   qb_l,   ~el);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000;
    $display("[TB] FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
